lsu_rmw: RTL
============

Name: lsu_rmw

Overview:
- Load/store unit between the CPU datapath and a word-wide synchronous data RAM with one-cycle read latency.
- Performs byte, halfword and word loads with sign or zero extension.
- Performs sub-word stores as read-modify-write sequences and word stores as single writes.
- Stalls the core through a req/busy/done handshake while an access is in flight.

Parameters:
- MEM_AW, 10, word-address width of the data RAM; RAM depth is 2**MEM_AW words.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- req_i  in  1  access request; sampled only in IDLE.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data; the value is taken from the LSBs.
- rdata_o  out  32  load result; registered.
- done_o  out  1  one-cycle pulse marking access completion.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- misaligned_o  out  1  valid with done_o; high means the access was rejected.
- mem_en_o  out  1  RAM enable.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  MEM_AW  RAM word address, taken from addr[MEM_AW+1:2].
- mem_wdata_o  out  32  RAM write data.
- mem_rdata_i  in  32  RAM read data; valid the cycle after an enable with we=0.

Behaviour:
- Reset, asynchronous on reset_ni low:
  - State goes to IDLE.
  - rdata_o=0, done_o=0, misaligned_o=0, mem_en_o=0, mem_we_o=0.
  - mem_addr_o=0, mem_wdata_o=0, internal address/size/data latches=0.
  - Reset asserted mid-access aborts the access: no write is issued afterwards and done_o does not pulse.
- States: IDLE, RD, RWAIT, WR, DONE.
- IDLE:
  - req_i=1 latches we, size, unsigned, addr and wdata.
  - Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned access goes to DONE with misaligned_o=1 and no RAM access.
  - Load, or byte/halfword store, goes to RD.
  - Aligned word store goes to WR.
- RD: mem_en_o=1, mem_we_o=0, mem_addr_o=latched word address; next state RWAIT.
- RWAIT: capture mem_rdata_i.
  - Load: extract the lane (byte lane addr[1:0], half lane addr[1]), extend it, register it into rdata_o, then go to DONE.
  - Store: merge the wdata LSBs into the selected lane(s) of the captured word, then go to WR.
- WR: mem_en_o=1, mem_we_o=1, mem_wdata_o = merged word (or wdata for a word store); next state DONE.
- DONE: done_o=1 for exactly one cycle; next state IDLE.
- Outside RD and WR, mem_en_o=0 and mem_we_o=0.
- Byte order is little-endian: byte 0 is bits 7:0.
- Latency, counting the accept edge as cycle 0 (done_o high during the cycle listed):
  - Misaligned: cycle 1.
  - Word store: cycle 2.
  - Load: cycle 3.
  - Sub-word store: cycle 4.
- busy_o=1 from cycle 1 through DONE inclusive; busy_o=0 in IDLE.
- req_i is ignored while busy.
- A request asserted during the DONE cycle is not accepted; it is accepted on the following IDLE cycle.
- rdata_o holds its value across stores and misaligned accesses; it changes only on a successful load.
- misaligned_o clears to 0 on the next accepted request.
- Address bits above MEM_AW+1 are ignored, so the address wraps modulo the RAM size.
- Unselected lanes of a sub-word store are written back unchanged.

Test Plan:
- Reset, then word store addr=0x10, wdata=0xDEADBEEF -> WR at cycle 1 with mem_addr=4 and wdata 0xDEADBEEF; done at cycle 2; busy 1 for cycles 1-2.
- RAM word 4 = 0x8081F0FF; byte load addr=0x12 signed -> rdata_o=0xFFFFFF81 at cycle 3; the same access with unsigned_i=1 -> 0x00000081.
- RAM word 4 = 0x11223344; halfword store addr=0x12, wdata=0xAAAA5566 -> RD, RWAIT, then WR of 0x55663344; done at cycle 4.
- Halfword load addr=0x13 -> done at cycle 1 with misaligned_o=1, mem_en never asserted, rdata_o unchanged.
- reset_ni pulsed low during the RWAIT of a byte store -> mem_we never asserted, RAM word unchanged, busy_o=0, no done pulse.
- req_i held high through a load -> second load accepted only after DONE; back-to-back done pulses 4 cycles apart.

Source files
------------

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit between the CPU datapath and a word-wide
// synchronous data RAM with one-cycle read latency.
//
// Loads of byte, halfword or word size are sign- or zero-extended into rdata_o.
// A sub-word store reads the target word, merges the new lane(s) into it and
// writes the word back. A word store is a single write. The core is stalled
// through req/busy/done while an access is in flight.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_ni     asynchronous active-low reset
//   req_i        access request, sampled only when idle
//   we_i         1 = store, 0 = load
//   size_i       00 byte, 01 halfword, 10/11 word
//   unsigned_i   loads: 1 = zero-extend, 0 = sign-extend
//   addr_i       byte address (bits above MEM_AW+1 ignored, address wraps)
//   wdata_i      store data, taken from the LSBs
//   rdata_o      registered load result, changes only on a successful load
//   done_o       one-cycle completion pulse
//   busy_o       high whenever an access is in flight
//   misaligned_o valid with done_o; high = access rejected, no RAM traffic
//   mem_en_o     RAM enable
//   mem_we_o     RAM write enable
//   mem_addr_o   RAM word address
//   mem_wdata_o  RAM write data
//   mem_rdata_i  RAM read data, valid the cycle after a read enable
module lsu_rmw #(
  parameter int unsigned MEM_AW = 10
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              misaligned_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RWAIT,
    S_WR,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [MEM_AW+1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                mis_q, mis_d;

  // Address bits above the RAM range are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:MEM_AW+2];

  // Request decode
  logic req_word;
  logic req_mis;

  assign req_word = size_i[1];
  assign req_mis  = ((size_i == 2'b01) && addr_i[0]) ||
                    (req_word && (addr_i[1:0] != 2'b00));

  // Lane selection from the returned RAM word
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    rd_byte = mem_rdata_i[7:0];
    case (addr_q[1:0])
      2'd0:    rd_byte = mem_rdata_i[7:0];
      2'd1:    rd_byte = mem_rdata_i[15:8];
      2'd2:    rd_byte = mem_rdata_i[23:16];
      default: rd_byte = mem_rdata_i[31:24];
    endcase
    rd_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  end

  always_comb begin
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: load_val = mem_rdata_i;
    endcase
  end

  // Read-modify-write merge: unselected lanes keep the value read from RAM.
  always_comb begin
    merged = mem_rdata_i;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = data_q[7:0];
          2'd1:    merged[15:8]  = data_q[7:0];
          2'd2:    merged[23:16] = data_q[7:0];
          default: merged[31:24] = data_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) begin
          merged[31:16] = data_q[15:0];
        end else begin
          merged[15:0]  = data_q[15:0];
        end
      end
      default: merged = data_q;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d   = we_i;
          size_d = size_i;
          uns_d  = unsigned_i;
          addr_d = addr_i[MEM_AW+1:0];
          data_d = wdata_i;
          mis_d  = req_mis;
          if (req_mis) begin
            state_d = S_DONE;
          end else if (we_i && req_word) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        state_d = S_RWAIT;
      end
      S_RWAIT: begin
        // The store data latch is reused to hold the merged word for WR.
        if (we_q) begin
          data_d  = merged;
          state_d = S_WR;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WR: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

  // Outputs
  assign rdata_o      = rdata_q;
  assign done_o       = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE);
  assign misaligned_o = mis_q;
  assign mem_en_o     = (state_q == S_RD) || (state_q == S_WR);
  assign mem_we_o     = (state_q == S_WR);
  assign mem_addr_o   = addr_q[MEM_AW+1:2];
  assign mem_wdata_o  = data_q;

endmodule
